// File: rtl/gate_unit_arbiter.sv
// Round-robin arbiter sharing one bitwise logic unit between NUM_REQ requesters.
// One operation in flight; result returned with the owning requester id.
module gate_unit_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned WIDTH   = 8,
    localparam int unsigned IDW    = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [3*NUM_REQ-1:0]     req_op,
    input  logic [WIDTH*NUM_REQ-1:0] req_a,
    input  logic [WIDTH*NUM_REQ-1:0] req_b,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [IDW-1:0]           rsp_id,
    output logic [WIDTH-1:0]         rsp_data,
    output logic                     busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t           r_state;
    logic [IDW-1:0]   r_rr_ptr;
    logic [IDW-1:0]   r_id;
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_rsp_valid;
    logic [IDW-1:0]   r_rsp_id;
    logic [WIDTH-1:0] r_rsp_data;
    logic             r_busy;

    logic             w_found;
    logic [IDW-1:0]   w_winner;
    logic [IDW-1:0]   w_next_ptr;
    logic [2:0]       w_sel_op;
    logic [WIDTH-1:0] w_sel_a;
    logic [WIDTH-1:0] w_sel_b;
    logic [WIDTH-1:0] w_result;
    logic             w_accept;

    // Two-pass scan: first indices at or above rr_ptr, then wrap to the low ones.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_sel_op = '0;
        w_sel_a  = '0;
        w_sel_b  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!w_found && req_valid[i] && (IDW'(i) >= r_rr_ptr)) begin
                w_found  = 1'b1;
                w_winner = IDW'(i);
                w_sel_op = req_op[3*i +: 3];
                w_sel_a  = req_a[WIDTH*i +: WIDTH];
                w_sel_b  = req_b[WIDTH*i +: WIDTH];
            end
        end
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!w_found && req_valid[i]) begin
                w_found  = 1'b1;
                w_winner = IDW'(i);
                w_sel_op = req_op[3*i +: 3];
                w_sel_a  = req_a[WIDTH*i +: WIDTH];
                w_sel_b  = req_b[WIDTH*i +: WIDTH];
            end
        end
    end

    assign w_accept   = rst_n && (r_state == S_IDLE) && w_found;
    assign w_next_ptr = (w_winner == IDW'(NUM_REQ - 1)) ? '0 : w_winner + IDW'(1);
    assign req_ready  = w_accept ? (NUM_REQ'(1) << w_winner) : '0;

    always_comb begin
        w_result = '0;
        case (r_op)
            3'b000:  w_result = r_a & r_b;
            3'b001:  w_result = r_a | r_b;
            3'b010:  w_result = ~r_a;
            3'b011:  w_result = ~r_b;
            3'b100:  w_result = ~(r_a & r_b);
            3'b101:  w_result = ~(r_a | r_b);
            3'b110:  w_result = r_a ^ r_b;
            default: w_result = ~(r_a ^ r_b);
        endcase
    end

    // IDLE -> EXEC -> RESP -> IDLE; reset discards any in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_rr_ptr    <= '0;
            r_id        <= '0;
            r_op        <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_data  <= '0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op     <= w_sel_op;
                        r_a      <= w_sel_a;
                        r_b      <= w_sel_b;
                        r_id     <= w_winner;
                        r_rr_ptr <= w_next_ptr;
                        r_state  <= S_EXEC;
                        r_busy   <= 1'b1;
                    end
                end
                S_EXEC: begin
                    r_rsp_data  <= w_result;
                    r_rsp_id    <= r_id;
                    r_rsp_valid <= 1'b1;
                    r_state     <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= S_IDLE;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_rsp_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_data  = r_rsp_data;
    assign busy      = r_busy;

endmodule

// File: tb/tb_gate_unit_arbiter.sv
// Self-checking bench for gate_unit_arbiter: scoreboard of expected responses
// pushed at each accept, plus per-scenario inline checks.
module tb_gate_unit_arbiter;

    localparam int NR = 4;
    localparam int W  = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NR-1:0]   req_valid;
    logic [NR-1:0]   req_ready;
    logic [3*NR-1:0] req_op;
    logic [W*NR-1:0] req_a;
    logic [W*NR-1:0] req_b;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [1:0]      rsp_id;
    logic [W-1:0]    rsp_data;
    logic            busy;

    typedef struct packed {
        logic [1:0]   id;
        logic [W-1:0] data;
    } exp_t;

    exp_t sb_q[$];
    int   grant_q[$];
    int   acc_cyc[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    gate_unit_arbiter #(.NUM_REQ(NR), .WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] gate_model(logic [2:0] op, logic [W-1:0] a, logic [W-1:0] b);
        case (op)
            3'd0: return a & b;
            3'd1: return a | b;
            3'd2: return ~a;
            3'd3: return ~b;
            3'd4: return ~(a & b);
            3'd5: return ~(a | b);
            3'd6: return a ^ b;
            default: return ~(a ^ b);
        endcase
    endfunction

    // Scoreboard monitor: push on accept, pop and compare on response handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            cyc = cyc + 1;
            if (req_ready !== '0) begin
                n_checks++;
                if (((req_ready & (req_ready - 1'b1)) != 0) || ((req_ready & ~req_valid) != 0)) begin
                    n_fail++;
                    $display("FAIL grant_onehot req_ready=%b req_valid=%b required one-hot subset of valid",
                             req_ready, req_valid);
                end
            end
            for (int i = 0; i < NR; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    exp_t e;
                    e.id   = 2'(i);
                    e.data = gate_model(req_op[3*i +: 3], req_a[W*i +: W], req_b[W*i +: W]);
                    sb_q.push_back(e);
                    grant_q.push_back(i);
                    acc_cyc.push_back(cyc);
                end
            end
            if (rsp_valid && rsp_ready) begin
                n_checks++;
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected rsp id=%0d data=%h required no response", rsp_id, rsp_data);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    if (rsp_id !== e.id || rsp_data !== e.data) begin
                        n_fail++;
                        $display("FAIL sb_rsp id=%0d data=%h required id=%0d data=%h",
                                 rsp_id, rsp_data, e.id, e.data);
                    end
                end
            end
        end
    end

    task automatic set_req(int id, logic [2:0] op, logic [W-1:0] a, logic [W-1:0] b);
        req_op[3*id +: 3] = op;
        req_a[W*id +: W]  = a;
        req_b[W*id +: W]  = b;
    endtask

    task automatic apply_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        sb_q.delete();
        grant_q.delete();
        acc_cyc.delete();
    endtask

    task automatic wait_drain(string nm);
        bit done = 0;
        n_checks++;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk); #1;
            if (!busy && sb_q.size() == 0 && req_valid == '0) done = 1;
        end
        if (!done) begin
            n_fail++;
            $display("FAIL %s_drain busy=%b pending=%0d required idle with no pending", nm, busy, sb_q.size());
        end
    endtask

    // Drive a single request and release it right after the accept edge.
    task automatic issue(int id, logic [2:0] op, logic [W-1:0] a, logic [W-1:0] b);
        bit ok = 0;
        @(posedge clk); #1;
        set_req(id, op, a, b);
        req_valid[id] = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (req_ready[id]) ok = 1;
        end
        @(posedge clk); #1;
        req_valid[id] = 1'b0;
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL issue_timeout id=%0d req_ready=%b required grant", id, req_ready);
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        rsp_ready = 1'b1;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        req_valid = '1;
        #12;
        n_checks++;
        if (req_ready !== 4'b0000 || rsp_valid !== 1'b0 || busy !== 1'b0 ||
            rsp_id !== 2'd0 || rsp_data !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_vals ready=%b rv=%b busy=%b id=%0d data=%h required 0000/0/0/0/00",
                     req_ready, rsp_valid, busy, rsp_id, rsp_data);
        end
        req_valid = '0;
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    task automatic test_single();
        @(posedge clk); #1;
        set_req(0, 3'b110, 8'hF0, 8'h3C);
        req_valid = 4'b0001;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL single_ready req_ready=%b required 0001", req_ready);
        end
        @(posedge clk); #1 req_valid = '0;
        @(negedge clk);
        n_checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_exec rv=%b busy=%b required 0/1", rsp_valid, busy);
        end
        @(negedge clk);
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== 8'hCC) begin
            n_fail++;
            $display("FAIL single_rsp rv=%b id=%0d data=%h required 1/0/cc", rsp_valid, rsp_id, rsp_data);
        end
        wait_drain("single");
    endtask

    task automatic test_round_robin();
        apply_reset();
        for (int i = 0; i < NR; i++)
            set_req(i, 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
        @(posedge clk); #1 req_valid = '1;
        for (int i = 0; i < 60 && grant_q.size() < 8; i++) begin
            @(negedge clk); #1;
        end
        @(posedge clk); #1 req_valid = '0;
        wait_drain("rr");
        n_checks++;
        if (grant_q.size() != 8) begin
            n_fail++;
            $display("FAIL rr_count grants=%0d required 8", grant_q.size());
        end else begin
            for (int k = 0; k < 8; k++) begin
                n_checks++;
                if (grant_q[k] != k % NR) begin
                    n_fail++;
                    $display("FAIL rr_order k=%0d got=%0d required %0d", k, grant_q[k], k % NR);
                end
            end
            for (int k = 1; k < 8; k++) begin
                n_checks++;
                if (acc_cyc[k] - acc_cyc[k-1] != 3) begin
                    n_fail++;
                    $display("FAIL rr_spacing k=%0d gap=%0d required 3", k, acc_cyc[k] - acc_cyc[k-1]);
                end
            end
        end
    endtask

    task automatic test_op_sweep();
        logic [W-1:0] tbl [8];
        tbl = '{8'h05, 8'hAF, 8'h5A, 8'hF0, 8'hFA, 8'h50, 8'hAA, 8'h55};
        for (int op = 0; op < 8; op++) begin
            bit seen = 0;
            issue(2, 3'(op), 8'hA5, 8'h0F);
            for (int i = 0; i < 10 && !seen; i++) begin
                @(negedge clk);
                if (rsp_valid) seen = 1;
            end
            n_checks++;
            if (!seen || rsp_data !== tbl[op] || rsp_id !== 2'd2) begin
                n_fail++;
                $display("FAIL op_sweep op=%0d rv=%b id=%0d data=%h required 1/2/%h",
                         op, rsp_valid, rsp_id, rsp_data, tbl[op]);
            end
        end
        wait_drain("sweep");
    endtask

    task automatic test_backpressure();
        logic [W-1:0] d;
        logic [1:0]   id;
        bit           seen = 0;
        rsp_ready = 1'b0;
        issue(1, 3'b001, 8'h12, 8'h84);
        @(posedge clk); #1 req_valid = '1;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1;
        end
        d  = rsp_data;
        id = rsp_id;
        n_checks++;
        if (!seen || d !== 8'h96 || id !== 2'd1) begin
            n_fail++;
            $display("FAIL bp_first rv=%b id=%0d data=%h required 1/1/96", rsp_valid, id, d);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== d || rsp_id !== id || req_ready !== 4'b0000) begin
                n_fail++;
                $display("FAIL bp_hold cyc=%0d rv=%b id=%0d data=%h ready=%b required 1/%0d/%h/0000",
                         i, rsp_valid, rsp_id, rsp_data, req_ready, id, d);
            end
        end
        @(posedge clk); #1 rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 4'b0100) begin
            n_fail++;
            $display("FAIL bp_resume rv=%b ready=%b required 0/0100", rsp_valid, req_ready);
        end
        @(posedge clk); #1 req_valid = '0;
        wait_drain("bp");
    endtask

    task automatic test_wrap();
        issue(1, 3'b000, 8'hFF, 8'h0F);
        wait_drain("wrap_pre");
        grant_q.delete();
        @(posedge clk); #1 req_valid = 4'b1001;
        for (int i = 0; i < 30 && grant_q.size() < 2; i++) begin
            @(negedge clk); #1;
        end
        @(posedge clk); #1 req_valid = '0;
        wait_drain("wrap");
        n_checks++;
        if (grant_q.size() < 2 || grant_q[0] != 3 || grant_q[1] != 0) begin
            n_fail++;
            $display("FAIL wrap_order n=%0d first=%0d second=%0d required 3 then 0", grant_q.size(),
                     (grant_q.size() > 0) ? grant_q[0] : -1, (grant_q.size() > 1) ? grant_q[1] : -1);
        end
    endtask

    task automatic test_reset_mid();
        bit bad = 0;
        issue(2, 3'b000, 8'hFF, 8'hFF);
        #3 rst_n = 1'b0;
        req_valid = '1;
        #1;
        n_checks++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0 || rsp_data !== 8'h00 ||
            rsp_id !== 2'd0 || req_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL rstmid_vals busy=%b rv=%b id=%0d data=%h ready=%b required 0/0/0/00/0000",
                     busy, rsp_valid, rsp_id, rsp_data, req_ready);
        end
        sb_q.delete();
        req_valid = '0;
        @(negedge clk); #1 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || busy !== 1'b0) bad = 1;
        end
        n_checks++;
        if (bad) begin
            n_fail++;
            $display("FAIL rstmid_norsp rv=%b busy=%b required no response after reset", rsp_valid, busy);
        end
        grant_q.delete();
        @(posedge clk); #1 req_valid = '1;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL rstmid_ptr req_ready=%b required 0001", req_ready);
        end
        @(posedge clk); #1 req_valid = '0;
        wait_drain("rstmid");
        n_checks++;
        if (grant_q.size() != 1 || grant_q[0] != 0) begin
            n_fail++;
            $display("FAIL rstmid_grant n=%0d required single grant to 0", grant_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_op_sweep();
        test_backpressure();
        test_wrap();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog sim time exceeded, required completion");
        $fatal(1, "watchdog");
    end

endmodule
